mdu_hilo: RTL and testbench

//   Multiply/divide unit with HI/LO registers, in the EX stage of the 5-stage MIPS pipeline.

---
 rtl/mdu_hilo_if.sv | 24 ++
 rtl/mdu_hilo.sv | 121 ++++++++++++
 tb/tb_mdu_hilo.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_if.sv
// MDU request/response bundle between EX-stage control and the HI/LO unit.
// master: drives start/op/operands/hilo_sel; slave: returns busy, hi, lo, hilo_out.
// Latency and backpressure are defined by mdu_hilo (busy stalls new requests).
interface mdu_hilo_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hilo_out;

  modport master (
    output start, op, rs_val, rt_val, hilo_sel,
    input  busy, hi, lo, hilo_out
  );

  modport slave (
    input  start, op, rs_val, rt_val, hilo_sel,
    output busy, hi, lo, hilo_out
  );
endinterface

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// Latency: MULT/MULTU commit MULT_CYCLES edges after start, DIV/DIVU after DIV_CYCLES; MTHI/MTLO next edge.
// Backpressure: busy is high while an op is in flight; any start during busy (incl. commit edge) is dropped.
// Ports: clk_i, rst_ni (async active-low), bus (slave modport: start/op/rs_val/rt_val/hilo_sel in,
//        busy/hi/lo/hilo_out out).
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  mdu_hilo_if.slave bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  // Counter only ever holds N-1, so clog2(N) bits are enough.
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    hi_q, lo_q;
  logic [31:0]    pend_hi_q, pend_lo_q;
  logic           pend_wr_q;

  // Result of the op presented this cycle; latched into pend_* on accept.
  logic [31:0]    pend_hi_d, pend_lo_d;
  logic           pend_wr_d;
  logic [63:0]    prod_s, prod_u;
  logic           div_signed;
  logic [31:0]    mag_a, mag_b, div_b, quo, rem;

  assign prod_s = {{32{bus.rs_val[31]}}, bus.rs_val} * {{32{bus.rt_val[31]}}, bus.rt_val};
  assign prod_u = {32'b0, bus.rs_val} * {32'b0, bus.rt_val};

  // Signed divide is done on magnitudes and sign-fixed afterwards, which makes
  // 0x80000000 / -1 fall out as 0x80000000 rem 0 without a special case.
  always_comb begin
    div_signed = (bus.op == OP_DIV);
    mag_a      = (div_signed && bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
    mag_b      = (div_signed && bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;
    div_b      = (bus.rt_val == 32'd0) ? 32'd1 : mag_b;  // keep the divider X-free on /0
    quo        = mag_a / div_b;
    rem        = mag_a % div_b;
    if (div_signed && (bus.rs_val[31] ^ bus.rt_val[31])) quo = -quo;
    if (div_signed && bus.rs_val[31])                    rem = -rem;

    pend_hi_d = 32'd0;
    pend_lo_d = 32'd0;
    pend_wr_d = 1'b1;
    case (bus.op)
      OP_MULT:  begin pend_hi_d = prod_s[63:32]; pend_lo_d = prod_s[31:0]; end
      OP_MULTU: begin pend_hi_d = prod_u[63:32]; pend_lo_d = prod_u[31:0]; end
      OP_DIV, OP_DIVU: begin
        pend_hi_d = rem;
        pend_lo_d = quo;
        pend_wr_d = (bus.rt_val != 32'd0);  // divide by zero leaves HI/LO untouched
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_q   <= BUSY;
                cnt_q     <= (bus.op[1]) ? DIV_LAST : MULT_LAST;
                pend_hi_q <= pend_hi_d;
                pend_lo_q <= pend_lo_d;
                pend_wr_q <= pend_wr_d;
              end
              OP_MTHI: hi_q <= bus.rs_val;
              OP_MTLO: lo_q <= bus.rs_val;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state_q == BUSY);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.hilo_out = bus.hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: vector table of MULT/DIV ops with a result scoreboard,
// plus hand sequences for divide-by-zero, ignored starts while busy / at commit,
// and asynchronous reset aborting an in-flight divide.
module tb_mdu_hilo;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];  // expected {hi, lo} pushed on start, popped at commit

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pop_compare(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: got empty queue expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_hi"}, bus.hi, e[63:32]);
      chk({tag, "_lo"}, bus.lo, e[31:0]);
      bus.hilo_sel = 1'b1; #1;
      chk({tag, "_out_hi"}, bus.hilo_out, e[63:32]);
      bus.hilo_sel = 1'b0; #1;
      chk({tag, "_out_lo"}, bus.hilo_out, e[31:0]);
    end
  endtask

  // Issue one multi-cycle op, check busy length and that HI/LO hold until commit.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int n);
    logic [31:0] old_hi, old_lo;
    int cnt;
    old_hi = bus.hi;
    old_lo = bus.lo;
    bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
    sb_q.push_back({ehi, elo});
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy_rise"}, {31'b0, bus.busy}, 32'd1);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      chk({tag, "_hold_hi"}, bus.hi, old_hi);
      chk({tag, "_hold_lo"}, bus.lo, old_lo);
      tick();
      cnt++;
    end
    chk({tag, "_busy_cycles"}, cnt, n);
    pop_compare(tag);
  endtask

  task automatic mt_op(input logic [2:0] o, input logic [31:0] a);
    bus.op = o; bus.rs_val = a; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd6; bus.rs_val = '0; bus.rt_val = '0; bus.hilo_sel = 1'b0;

    vecs[0] = '{3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[3] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        10};
    vecs[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[6] = '{3'd0, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 5};
    vecs[7] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
    vecs[9] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};

    #12;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].hi, vecs[i].lo, vecs[i].n);
    end

    // Divide by zero keeps HI/LO but still occupies the unit.
    mt_op(3'd4, 32'h11);
    chk("mthi", bus.hi, 32'h11);
    mt_op(3'd5, 32'h22);
    chk("mtlo", bus.lo, 32'h22);
    chk("mt_busy", {31'b0, bus.busy}, 32'd0);
    run_op("divz", 3'd2, 32'd5, 32'd0, 32'h11, 32'h22, 10);

    // No-op codes leave everything alone.
    mt_op(3'd6, 32'hDEADBEEF);
    mt_op(3'd7, 32'hDEADBEEF);
    chk("nop_hi", bus.hi, 32'h11);
    chk("nop_lo", bus.lo, 32'h22);
    chk("nop_busy", {31'b0, bus.busy}, 32'd0);

    // MULT 3*4 with MTHI held on start through the busy window, then MTLO
    // presented on the commit edge (dropped) and accepted one edge later.
    bus.op = 3'd0; bus.rs_val = 32'd3; bus.rt_val = 32'd4; bus.start = 1'b1;
    sb_q.push_back({32'd0, 32'd12});
    tick();                                   // edge t: accepted
    bus.op = 3'd4; bus.rs_val = 32'hAAAA;
    for (int k = 1; k <= 4; k++) begin
      tick();                                 // edges t+1..t+4: MTHI ignored
      chk("mid_busy", {31'b0, bus.busy}, 32'd1);
      chk("mid_hi", bus.hi, 32'h11);
    end
    bus.op = 3'd5; bus.rs_val = 32'h5555;
    tick();                                   // edge t+5: commit, MTLO dropped
    chk("commit_busy", {31'b0, bus.busy}, 32'd0);
    pop_compare("mult_ign");
    bus.rs_val = 32'h1234;
    tick();                                   // edge t+6: MTLO accepted
    bus.start = 1'b0;
    bus.hilo_sel = 1'b0; #1;
    chk("mtlo_after", bus.hilo_out, 32'h1234);
    chk("mtlo_after_busy", {31'b0, bus.busy}, 32'd0);
    chk("mthi_dropped", bus.hi, 32'd0);

    // Async reset in the middle of a divide.
    bus.op = 3'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    #3 rst_ni = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("post_rst_lo", bus.lo, 32'd0);
    end
    bus.hilo_sel = 1'b1; #1;
    chk("post_rst_out_hi", bus.hilo_out, 32'd0);
    bus.hilo_sel = 1'b0; #1;
    chk("post_rst_out_lo", bus.hilo_out, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
